// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Load-use / ECALL hazard unit for a 5-stage RISC-V pipeline, placed in ID
//   beside the IF/ID register. Each architectural register (x1..x31) has two
//   countdown counters:
//     fwd_cnt : cycles until a load result can be forwarded to an ID consumer
//     wb_cnt  : cycles until rd is readable straight from the regfile (used by
//               ECALL, which reads ECALL_REG without forwarding)
//   A taken branch/jump in EX squashes the instruction that issued last cycle,
//   so the counters it set are rolled back to what they would have been.
//
// Ports
//   clk_i            clock
//   reset_n_i        synchronous reset, active-low
//   if_id_valid_i    IF/ID holds a live instruction
//   if_id_inst_i     32-bit instruction in ID
//   flush_i          branch/jump taken in EX: EX and ID instructions squashed
//   mem_stall_i      data memory not ready: whole pipeline frozen this cycle
//   hazard_o         ID instruction must not issue this cycle
//   pc_write_o       PC update enable
//   if_id_write_o    IF/ID write enable
//   id_ex_bubble_o   load NOP into ID/EX at next edge
//   stall_cause_o    0 none, 1 load-use, 2 ecall, 3 mem_stall
module hazard_scoreboard #(
    parameter int REG_CNT   = 32,
    parameter int LOAD_LAT  = 1,
    parameter int WB_LAT    = 2,
    parameter int ECALL_REG = 17,
    parameter int CNT_W     = 2
) (
    input  logic        clk_i,
    input  logic        reset_n_i,
    input  logic        if_id_valid_i,
    input  logic [31:0] if_id_inst_i,
    input  logic        flush_i,
    input  logic        mem_stall_i,
    output logic        hazard_o,
    output logic        pc_write_o,
    output logic        if_id_write_o,
    output logic        id_ex_bubble_o,
    output logic [1:0]  stall_cause_o
);

    localparam int IDX_W = $clog2(REG_CNT);

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [31:0] INST_ECALL = 32'h0000_0073;

    // Counters must be able to hold the largest latency loaded into them.
    if (((1 << CNT_W) <= LOAD_LAT) || ((1 << CNT_W) <= WB_LAT)) begin : g_cnt_w_check
        $error("hazard_scoreboard: CNT_W too narrow for LOAD_LAT/WB_LAT");
    end

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] v);
        return (v == '0) ? '0 : v - CNT_W'(1);
    endfunction

    // ---------------- decode ----------------
    logic [6:0]       opcode;
    logic [IDX_W-1:0] rd, rs1, rs2;
    logic             use_rs1, use_rs2, writes_rd, is_load, is_ecall;

    always_comb begin
        opcode    = if_id_inst_i[6:0];
        rd        = if_id_inst_i[7  +: IDX_W];
        rs1       = if_id_inst_i[15 +: IDX_W];
        rs2       = if_id_inst_i[20 +: IDX_W];
        is_load   = (opcode == OPC_LOAD);
        is_ecall  = (if_id_inst_i == INST_ECALL);
        use_rs1   = (opcode == OPC_OPIMM) || (opcode == OPC_LOAD)  || (opcode == OPC_JALR) ||
                    (opcode == OPC_OP)    || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
        use_rs2   = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);
        writes_rd = ((opcode == OPC_OP)  || (opcode == OPC_OPIMM) || (opcode == OPC_LOAD) ||
                     (opcode == OPC_JAL) || (opcode == OPC_JALR)  || (opcode == OPC_LUI)  ||
                     (opcode == OPC_AUIPC)) && (rd != '0);
    end

    // ---------------- state ----------------
    logic [CNT_W-1:0] fwd_cnt_q [REG_CNT];
    logic [CNT_W-1:0] wb_cnt_q  [REG_CNT];
    logic [CNT_W-1:0] fwd_cnt_d [REG_CNT];
    logic [CNT_W-1:0] wb_cnt_d  [REG_CNT];
    logic [IDX_W-1:0] last_rd_q;
    logic             last_vld_q;
    logic [CNT_W-1:0] prev_fwd_q, prev_wb_q;

    logic load_use, ecall_h, issue, rollback;

    always_comb begin
        load_use = if_id_valid_i &&
                   ((use_rs1 && (rs1 != '0) && (fwd_cnt_q[rs1] != '0)) ||
                    (use_rs2 && (rs2 != '0) && (fwd_cnt_q[rs2] != '0)));
        ecall_h  = if_id_valid_i && is_ecall && (wb_cnt_q[ECALL_REG] != '0);
    end

    // ---------------- output priority ----------------
    always_comb begin
        hazard_o       = 1'b0;
        pc_write_o     = 1'b1;
        if_id_write_o  = 1'b1;
        id_ex_bubble_o = 1'b0;
        stall_cause_o  = 2'd0;
        if (!reset_n_i) begin
            hazard_o       = 1'b1;
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
        end else if (mem_stall_i) begin
            // ID/EX holds its content, so no bubble is injected.
            hazard_o       = 1'b1;
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            stall_cause_o  = 2'd3;
        end else if (flush_i) begin
            // The ID instruction is squashed; the fetch redirect must proceed.
            id_ex_bubble_o = 1'b1;
        end else if (ecall_h || load_use) begin
            hazard_o       = 1'b1;
            pc_write_o     = 1'b0;
            if_id_write_o  = 1'b0;
            id_ex_bubble_o = 1'b1;
            stall_cause_o  = ecall_h ? 2'd2 : 2'd1;
        end
    end

    assign issue    = reset_n_i && if_id_valid_i && !mem_stall_i && !flush_i && !hazard_o;
    assign rollback = flush_i && last_vld_q;

    // ---------------- per-register next state ----------------
    for (genvar gi = 0; gi < REG_CNT; gi++) begin : g_reg
        if (gi == 0) begin : g_x0
            assign fwd_cnt_d[gi] = '0;
            assign wb_cnt_d[gi]  = '0;
        end else begin : g_xn
            logic hit_issue, hit_rollback;
            assign hit_issue    = issue && writes_rd && (rd == IDX_W'(gi));
            assign hit_rollback = rollback && (last_rd_q == IDX_W'(gi));
            // prev_* already account for the issue cycle; one more decrement
            // covers the flush cycle itself.
            assign fwd_cnt_d[gi] = hit_issue    ? (is_load ? CNT_W'(LOAD_LAT) : '0) :
                                   hit_rollback ? dec_sat(prev_fwd_q) :
                                                  dec_sat(fwd_cnt_q[gi]);
            assign wb_cnt_d[gi]  = hit_issue    ? CNT_W'(WB_LAT) :
                                   hit_rollback ? dec_sat(prev_wb_q) :
                                                  dec_sat(wb_cnt_q[gi]);
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            for (int i = 0; i < REG_CNT; i++) begin
                fwd_cnt_q[i] <= '0;
                wb_cnt_q[i]  <= '0;
            end
            last_vld_q <= 1'b0;
            last_rd_q  <= '0;
            prev_fwd_q <= '0;
            prev_wb_q  <= '0;
        end else if (!mem_stall_i) begin
            fwd_cnt_q <= fwd_cnt_d;
            wb_cnt_q  <= wb_cnt_d;
            if (issue && writes_rd) begin
                // Remember what rd's counters would have become without this
                // issue, so a flush next cycle can restore them.
                prev_fwd_q <= dec_sat(fwd_cnt_q[rd]);
                prev_wb_q  <= dec_sat(wb_cnt_q[rd]);
                last_rd_q  <= rd;
                last_vld_q <= 1'b1;
            end else begin
                last_vld_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
module tb_hazard_scoreboard;

    logic        clk;
    logic        reset_n;
    logic        if_id_valid;
    logic [31:0] if_id_inst;
    logic        flush;
    logic        mem_stall;

    logic        hz1, pcw1, ifw1, bub1;
    logic [1:0]  cause1;
    logic        hz2, pcw2, ifw2, bub2;
    logic [1:0]  cause2;

    // Default latencies.
    hazard_scoreboard dut1 (
        .clk_i(clk), .reset_n_i(reset_n), .if_id_valid_i(if_id_valid),
        .if_id_inst_i(if_id_inst), .flush_i(flush), .mem_stall_i(mem_stall),
        .hazard_o(hz1), .pc_write_o(pcw1), .if_id_write_o(ifw1),
        .id_ex_bubble_o(bub1), .stall_cause_o(cause1)
    );

    // Long load latency variant.
    hazard_scoreboard #(.LOAD_LAT(3), .WB_LAT(3), .CNT_W(2)) dut2 (
        .clk_i(clk), .reset_n_i(reset_n), .if_id_valid_i(if_id_valid),
        .if_id_inst_i(if_id_inst), .flush_i(flush), .mem_stall_i(mem_stall),
        .hazard_o(hz2), .pc_write_o(pcw2), .if_id_write_o(ifw2),
        .id_ex_bubble_o(bub2), .stall_cause_o(cause2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected output vectors {hazard, pc_write, if_id_write, id_ex_bubble, cause[1:0]}
    localparam logic [5:0] NRM = {1'b0, 1'b1, 1'b1, 1'b0, 2'd0};
    localparam logic [5:0] LU  = {1'b1, 1'b0, 1'b0, 1'b1, 2'd1};
    localparam logic [5:0] EC  = {1'b1, 1'b0, 1'b0, 1'b1, 2'd2};
    localparam logic [5:0] MS  = {1'b1, 1'b0, 1'b0, 1'b0, 2'd3};
    localparam logic [5:0] FL  = {1'b0, 1'b1, 1'b1, 1'b1, 2'd0};
    localparam logic [5:0] RST = {1'b1, 1'b0, 1'b0, 1'b1, 2'd0};

    localparam logic [31:0] ECALL = 32'h0000_0073;

    typedef struct {
        string      name;
        int         sel;   // 0: dut1, 1: dut2, 2: both
        logic [5:0] exp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] enc_r(input int rd, input int rs1, input int rs2);
        return {7'b0, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_addi(input int rd, input int rs1, input int imm);
        return {12'(imm), 5'(rs1), 3'b000, 5'(rd), 7'b0010011};
    endfunction

    function automatic logic [31:0] enc_lw(input int rd, input int rs1);
        return {12'd0, 5'(rs1), 3'b010, 5'(rd), 7'b0000011};
    endfunction

    // Drive one cycle of inputs and queue the response expected during it.
    task automatic step(input string nm, input int sel, input logic [5:0] e,
                        input logic rstn, input logic v, input logic [31:0] ins,
                        input logic fl, input logic ms);
        exp_t t;
        @(posedge clk);
        #1;
        reset_n     = rstn;
        if_id_valid = v;
        if_id_inst  = ins;
        flush       = fl;
        mem_stall   = ms;
        t.name = nm;
        t.sel  = sel;
        t.exp  = e;
        exp_q.push_back(t);
    endtask

    task automatic cmp(input string nm, input int d, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got {hz,pcw,ifw,bub,cause}=%b, required %b", nm, d, act, exp);
        end
    endtask

    // Monitor: outputs are presented every cycle; compare mid-cycle.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t t;
            t = exp_q.pop_front();
            if (t.sel != 1) cmp(t.name, 1, {hz1, pcw1, ifw1, bub1, cause1}, t.exp);
            if (t.sel != 0) cmp(t.name, 2, {hz2, pcw2, ifw2, bub2, cause2}, t.exp);
            $display("check %-22s sel=%0d exp=%b dut1=%b dut2=%b", t.name, t.sel, t.exp,
                     {hz1, pcw1, ifw1, bub1, cause1}, {hz2, pcw2, ifw2, bub2, cause2});
        end
    end

    initial begin
        int waited;
        reset_n = 1'b0; if_id_valid = 1'b0; if_id_inst = '0; flush = 1'b0; mem_stall = 1'b0;

        step("reset0", 2, RST, 0, 0, 32'h0, 0, 0);
        step("reset1", 2, RST, 0, 1, enc_r(6, 5, 2), 0, 0);

        // ALU producer never stalls an ALU consumer
        step("alu_addi_x10", 0, NRM, 1, 1, enc_addi(10, 0, 5), 0, 0);
        step("alu_add_x11",  0, NRM, 1, 1, enc_r(11, 10, 10), 0, 0);

        // Back-to-back load-use: exactly one bubble
        step("lu_lw_x5",     0, NRM, 1, 1, enc_lw(5, 1), 0, 0);
        step("lu_add_stall", 0, LU,  1, 1, enc_r(6, 5, 2), 0, 0);
        step("lu_add_issue", 0, NRM, 1, 1, enc_r(6, 5, 2), 0, 0);
        step("lu_idle",      0, NRM, 1, 0, 32'h0, 0, 0);

        // ECALL after write of x17: two stall cycles
        step("ec_addi_x17",  0, NRM, 1, 1, enc_addi(17, 0, 93), 0, 0);
        step("ec_stall1",    0, EC,  1, 1, ECALL, 0, 0);
        step("ec_stall2",    0, EC,  1, 1, ECALL, 0, 0);
        step("ec_issue",     0, NRM, 1, 1, ECALL, 0, 0);

        // Memory stall freezes counters; one load-use bubble remains after it
        step("ms_lw_x5",     0, NRM, 1, 1, enc_lw(5, 1), 0, 0);
        step("ms_stall1",    0, MS,  1, 1, enc_r(6, 5, 2), 0, 1);
        step("ms_stall2",    0, MS,  1, 1, enc_r(6, 5, 2), 0, 1);
        step("ms_stall3",    0, MS,  1, 1, enc_r(6, 5, 2), 0, 1);
        step("ms_lu_bubble", 0, LU,  1, 1, enc_r(6, 5, 2), 0, 0);
        step("ms_add_issue", 0, NRM, 1, 1, enc_r(6, 5, 2), 0, 0);

        // Flush squashes the load in EX
        step("fl_lw_x7",     0, NRM, 1, 1, enc_lw(7, 1), 0, 0);
        step("fl_flush",     0, FL,  1, 1, enc_r(8, 7, 0), 1, 0);
        step("fl_add_x9",    0, NRM, 1, 1, enc_r(9, 7, 0), 0, 0);

        // Flush of an x17 writer rolls back its write-back countdown
        step("flx17_addi",   0, NRM, 1, 1, enc_addi(17, 0, 93), 0, 0);
        step("flx17_flush",  0, FL,  1, 1, ECALL, 1, 0);
        step("flx17_ecall",  0, NRM, 1, 1, ECALL, 0, 0);

        // x0 is never tracked
        step("x0_lw",        0, NRM, 1, 1, enc_lw(0, 1), 0, 0);
        step("x0_add",       0, NRM, 1, 1, enc_r(3, 0, 0), 0, 0);

        // Reset during a load-use stall clears pending hazards
        step("rs_lw_x5",     0, NRM, 1, 1, enc_lw(5, 1), 0, 0);
        step("rs_lu",        0, LU,  1, 1, enc_r(6, 5, 2), 0, 0);
        step("rs_reset",     2, RST, 0, 1, enc_r(6, 5, 2), 0, 0);
        step("rs_after",     2, NRM, 1, 1, enc_r(6, 5, 2), 0, 0);

        // LOAD_LAT=3 instance: three bubbles
        step("l3_lw_x5",     1, NRM, 1, 1, enc_lw(5, 1), 0, 0);
        step("l3_lu1",       1, LU,  1, 1, enc_r(6, 5, 2), 0, 0);
        step("l3_lu2",       1, LU,  1, 1, enc_r(6, 5, 2), 0, 0);
        step("l3_lu3",       1, LU,  1, 1, enc_r(6, 5, 2), 0, 0);
        step("l3_issue",     1, NRM, 1, 1, enc_r(6, 5, 2), 0, 0);

        // LOAD_LAT=3 instance: flush rollback returns x7 to idle
        step("l3fl_lw_x7",   1, NRM, 1, 1, enc_lw(7, 1), 0, 0);
        step("l3fl_flush",   1, FL,  1, 1, enc_r(8, 7, 0), 1, 0);
        step("l3fl_add_x9",  1, NRM, 1, 1, enc_r(9, 7, 0), 0, 0);
        step("idle_end",     2, NRM, 1, 0, 32'h0, 0, 0);

        waited = 0;
        while (exp_q.size() > 0 && waited < 20) begin
            @(posedge clk);
            waited++;
        end
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
